// File: rtl/chi_inv_step_if.sv
// Keccak shared constants/types and the valid/ready bus for the inverse chi block.
package keccak_pkg;
  localparam int unsigned ROW_SIZE  = 5;
  localparam int unsigned COL_SIZE  = 5;
  localparam int unsigned LANE_SIZE = 64;

  // Full Keccak state, indexed [x][y][z].
  typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_t;
endpackage

// Input and output handshakes plus the state payloads.
interface chi_inv_step_if;
  import keccak_pkg::*;

  logic   in_valid_i;
  logic   in_ready_o;
  state_t state_array_i;
  logic   out_valid_o;
  logic   out_ready_i;
  state_t state_array_o;

  modport slave (
    input  in_valid_i, state_array_i, out_ready_i,
    output in_ready_o, out_valid_o, state_array_o
  );

  modport master (
    output in_valid_i, state_array_i, out_ready_i,
    input  in_ready_o, out_valid_o, state_array_o
  );
endinterface

// File: rtl/chi_inv_step.sv
// Sequential Keccak chi inverse: six in-place lane-column updates (x = 0,3,1,4,2,0),
// every row and bit in parallel, one column per cycle, one state in flight.
module chi_inv_step
  import keccak_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  chi_inv_step_if.slave bus,
  output logic          busy_o
);

  localparam int unsigned NUM_STEPS = 6;
  localparam int unsigned STEP_W    = 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_e;

  fsm_e              state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  state_t            b_q, b_d;
  state_t            c_q, c_d;
  logic [2:0]        col_x;

  // Column updated by each step: X = 3*step mod 5 as a fixed table.
  always_comb begin
    col_x = 3'd0;
    case (step_q)
      3'd0:    col_x = 3'd0;
      3'd1:    col_x = 3'd3;
      3'd2:    col_x = 3'd1;
      3'd3:    col_x = 3'd4;
      3'd4:    col_x = 3'd2;
      3'd5:    col_x = 3'd0;
      default: col_x = 3'd0;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  // Next state, step counter and the single-column recovery update.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    b_d     = b_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid_i) begin
          b_d     = bus.state_array_i;
          c_d     = bus.state_array_i;
          step_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int unsigned x = 0; x < ROW_SIZE; x++) begin
          if (col_x == 3'(x)) begin
            for (int unsigned y = 0; y < COL_SIZE; y++) begin
              c_d[x][y] = b_q[x][y] ^
                          (c_q[(x + 2) % ROW_SIZE][y] & ~c_q[(x + 1) % ROW_SIZE][y]);
            end
          end
        end
        if (step_q == STEP_W'(NUM_STEPS - 1)) begin
          state_d = S_DONE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake flags decode the FSM register only; result always reflects c_q.
  assign bus.in_ready_o    = (state_q == S_IDLE);
  assign bus.out_valid_o   = (state_q == S_DONE);
  assign busy_o            = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.state_array_o = c_q;

endmodule

// File: tb/tb_chi_inv_step.sv
// Directed and round-trip bench for chi_inv_step.
module tb_chi_inv_step;
  import keccak_pkg::*;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_pass;
  int   n_total;

  chi_inv_step_if bus ();

  chi_inv_step dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Forward chi: A[x] ^ (~A[x+1] & A[x+2]).
  function automatic state_t chi(input state_t a);
    state_t r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[x][y] = a[x][y] ^ (~a[(x + 1) % 5][y] & a[(x + 2) % 5][y]);
    return r;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = {$urandom, $urandom};
    return s;
  endfunction

  // Prints the first differing lane of two states.
  function automatic void fail_state(input string name, input state_t got, input state_t want);
    int d;
    d = 0;
    for (int i = 24; i >= 0; i--)
      if (got[i / 5][i % 5] !== want[i / 5][i % 5]) d = i;
    $display("FAIL %s: lane[%0d][%0d] got %h want %h", name, d / 5, d % 5,
             got[d / 5][d % 5], want[d / 5][d % 5]);
  endfunction

  task automatic accept(input state_t b, input bit keep_valid, output bit ok);
    bus.state_array_i = b;
    bus.in_valid_i    = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (bus.in_ready_o) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!keep_valid) bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid_o && lat < 32) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    n_total++;
    if ({bus.in_ready_o, bus.out_valid_o, busy} !== 3'b100) begin
      $display("FAIL reset_flags: got rdy/vld/busy %b want 100", {bus.in_ready_o, bus.out_valid_o, busy});
    end else n_pass++;
    n_total++;
    if (bus.state_array_o !== state_t'('0)) fail_state("reset_state", bus.state_array_o, '0);
    else n_pass++;
  endtask

  task automatic test_single_bit();
    state_t b, want;
    bit ok;
    int lat;
    b = '0; b[0][0] = 64'h1; b[3][0] = 64'h1;
    want = '0; want[0][0] = 64'h1;
    accept(b, 1'b0, ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL single_accept: got %0b want 1", ok);
    else n_pass++;
    wait_out(lat);
    n_total++;
    if (lat !== 6 || bus.out_valid_o !== 1'b1) $display("FAIL single_latency: got %0d want 6", lat);
    else n_pass++;
    n_total++;
    if (bus.state_array_o !== want) fail_state("single_result", bus.state_array_o, want);
    else n_pass++;
    consume();
    n_total++;
    if ({bus.in_ready_o, bus.out_valid_o, busy} !== 3'b100) begin
      $display("FAIL single_idle: got rdy/vld/busy %b want 100", {bus.in_ready_o, bus.out_valid_o, busy});
    end else n_pass++;
  endtask

  task automatic test_fixed_points();
    state_t v;
    bit ok;
    int lat;
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? state_t'('0) : ~state_t'('0);
      accept(v, 1'b0, ok);
      wait_out(lat);
      n_total++;
      if (bus.out_valid_o !== 1'b1 || bus.state_array_o !== v) fail_state("fixed_point", bus.state_array_o, v);
      else n_pass++;
      consume();
    end
  endtask

  task automatic test_per_step();
    int xs [6] = '{0, 3, 1, 4, 2, 0};
    state_t a, b, g;
    bit ok;
    int cx;
    a = rand_state();
    b = chi(a);
    g = b;
    accept(b, 1'b0, ok);
    for (int s = 0; s < 6; s++) begin
      @(posedge clk); #1;
      cx = xs[s];
      for (int y = 0; y < 5; y++)
        g[cx][y] = b[cx][y] ^ (g[(cx + 2) % 5][y] & ~g[(cx + 1) % 5][y]);
      n_total++;
      if (dut.c_q !== g) fail_state($sformatf("step%0d", s), dut.c_q, g);
      else n_pass++;
    end
    n_total++;
    if (bus.out_valid_o !== 1'b1 || bus.state_array_o !== a) fail_state("step_final", bus.state_array_o, a);
    else n_pass++;
    consume();
  endtask

  task automatic test_back_pressure();
    state_t a, junk;
    bit ok;
    int lat;
    a = rand_state();
    accept(chi(a), 1'b0, ok);
    wait_out(lat);
    junk = rand_state();
    bus.state_array_i = junk;
    bus.in_valid_i    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0 || bus.state_array_o !== a)
        fail_state($sformatf("bp_hold%0d vld=%b rdy=%b", i, bus.out_valid_o, bus.in_ready_o), bus.state_array_o, a);
      else n_pass++;
    end
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    n_total++;
    if ({bus.in_ready_o, bus.out_valid_o, busy} !== 3'b100) begin
      $display("FAIL bp_release: got rdy/vld/busy %b want 100", {bus.in_ready_o, bus.out_valid_o, busy});
    end else n_pass++;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic test_round_trip();
    state_t av [200];
    bit ok;
    int lat;
    int bad;
    for (int i = 0; i < 200; i++) av[i] = rand_state();
    for (int i = 0; i < 200; i++) begin
      accept(chi(av[i]), (i % 2) == 0, ok);
      if ((i % 2) == 0) bus.state_array_i = chi(av[i + 1]);
      else bus.state_array_i = rand_state();
      bad = 0;
      lat = 0;
      while (!bus.out_valid_o && lat < 32) begin
        if (bus.in_ready_o) bad++;
        @(posedge clk); #1;
        lat++;
      end
      if (bus.in_ready_o) bad++;
      n_total++;
      if (bad !== 0 || lat !== 6) $display("FAIL rt_busy%0d: ready-high cycles %0d latency %0d want 0 and 6", i, bad, lat);
      else n_pass++;
      n_total++;
      if (bus.state_array_o !== av[i]) fail_state($sformatf("rt_result%0d", i), bus.state_array_o, av[i]);
      else n_pass++;
      consume();
      if ((i % 2) == 0) begin
        n_total++;
        if ({bus.in_ready_o, busy} !== 2'b10) $display("FAIL rt_overlap%0d: got rdy/busy %b want 10", i, {bus.in_ready_o, busy});
        else n_pass++;
      end
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    state_t a;
    bit ok;
    int lat;
    a = rand_state();
    accept(chi(a), 1'b0, ok);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.in_ready_o, bus.out_valid_o, busy} !== 3'b100) begin
      $display("FAIL midrun_flags: got rdy/vld/busy %b want 100", {bus.in_ready_o, bus.out_valid_o, busy});
    end else n_pass++;
    n_total++;
    if (bus.state_array_o !== state_t'('0)) fail_state("midrun_state", bus.state_array_o, '0);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    a = rand_state();
    accept(chi(a), 1'b0, ok);
    wait_out(lat);
    n_total++;
    if (lat !== 6 || bus.state_array_o !== a) fail_state($sformatf("after_reset lat=%0d", lat), bus.state_array_o, a);
    else n_pass++;
    consume();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    bus.in_valid_i    = 1'b0;
    bus.out_ready_i   = 1'b0;
    bus.state_array_i = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_single_bit();
    test_fixed_points();
    test_per_step();
    test_back_pressure();
    test_round_trip();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
